// File: rtl/fb_pkg.sv
// Shared frame-store constants, FSM encoding and pixel-address helper
// for the 640x480 double-buffered frame store.
package fb_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 3;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    DRAW      = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_e;

  // Linear address y*640+x, built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [9:0] x,
                                                   input logic [8:0] y);
    return ADDR_W'({y, 9'b0}) + ADDR_W'({y, 7'b0}) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Back-bank clear sweep: writes a fixed color to every address 0..DEPTH-1,
// one per cycle. Comes out of reset already sweeping; start_i restarts at 0.
module fb_clear_engine #(
  parameter int                DEPTH       = 307200,
  parameter int                DATA_W      = 3,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [fb_pkg::ADDR_W-1:0] addr_o,
  output logic                      we_o,
  output logic [DATA_W-1:0]         wdata_o
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              at_last;

  assign at_last = (ptr_q == LAST_ADDR);

  always_comb begin
    busy_d = busy_q;
    ptr_d  = ptr_q;
    if (start_i) begin
      busy_d = 1'b1;
      ptr_d  = '0;
    end else if (busy_q) begin
      if (at_last) begin
        busy_d = 1'b0;
        ptr_d  = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b1;
      ptr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = busy_q & at_last;
  assign addr_o  = ptr_q;
  assign we_o    = busy_q;
  assign wdata_o = CLEAR_COLOR;

endmodule

// File: rtl/fb_controller.sv
// Double-buffer controller: front bank feeds scanout, back bank is cleared
// then drawn by the renderer; banks swap on vsync after frame_done.
//
// state     | meaning
// CLEAR     | clear engine sweeping the back bank, renderer stalled
// DRAW      | renderer writes accepted into the back bank
// WAIT_SWAP | frame committed, waiting for the next vsync rising edge
module fb_controller #(
  parameter int               H_RES       = 640,
  parameter int               V_RES       = 480,
  parameter int               PIX_W       = 3,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = '0,
  parameter int               CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vsync,
  input  logic [fb_pkg::ADDR_W-1:0] scan_addr,
  output logic [PIX_W-1:0]          scan_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [9:0]                wr_x,
  input  logic [8:0]                wr_y,
  input  logic [PIX_W-1:0]          wr_color,
  input  logic                      frame_done,
  output logic [fb_pkg::ADDR_W-1:0] bank0_addr,
  output logic                      bank0_we,
  output logic [PIX_W-1:0]          bank0_wdata,
  input  logic [PIX_W-1:0]          bank0_rdata,
  output logic [fb_pkg::ADDR_W-1:0] bank1_addr,
  output logic                      bank1_we,
  output logic [PIX_W-1:0]          bank1_wdata,
  input  logic [PIX_W-1:0]          bank1_rdata,
  output logic                      front_sel,
  output logic                      busy_clear,
  output logic [CNT_W-1:0]          frames_dropped
);
  import fb_pkg::*;

  localparam int         DEPTH = H_RES * V_RES;
  localparam logic [9:0] X_LIM = 10'(H_RES);
  localparam logic [8:0] Y_LIM = 9'(V_RES);

  fb_state_e         state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic              scan_sel_q;
  logic              vsync_q;
  logic [CNT_W-1:0]  dropped_q, dropped_d;
  logic              vs_edge;
  logic              count_drop;

  logic              clr_start, clr_busy, clr_done, clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [PIX_W-1:0]  clr_wdata;

  logic              wr_fire, wr_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] back_addr;
  logic              back_we;
  logic [PIX_W-1:0]  back_wdata;

  fb_clear_engine #(
    .DEPTH      (DEPTH),
    .DATA_W     (PIX_W),
    .CLEAR_COLOR(CLEAR_COLOR)
  ) u_clear (
    .clk    (clk),
    .reset  (reset),
    .start_i(clr_start),
    .busy_o (clr_busy),
    .done_o (clr_done),
    .addr_o (clr_addr),
    .we_o   (clr_we),
    .wdata_o(clr_wdata)
  );

  assign vs_edge     = vsync & ~vsync_q;
  assign wr_ready    = ~reset & (state_q == DRAW);
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = (wr_x < X_LIM) && (wr_y < Y_LIM);
  assign wr_addr     = xy_to_addr(wr_x, wr_y);

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    dropped_d   = dropped_q;
    clr_start   = 1'b0;
    count_drop  = 1'b0;
    case (state_q)
      CLEAR: begin
        count_drop = vs_edge;
        if (clr_done) state_d = DRAW;
      end
      DRAW: begin
        // A vsync edge here is dropped even when frame_done arrives with it.
        count_drop = vs_edge;
        if (frame_done) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (vs_edge) begin
          front_sel_d = ~front_sel_q;
          clr_start   = 1'b1;
          state_d     = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
    if (count_drop && (dropped_q != {CNT_W{1'b1}})) begin
      dropped_d = dropped_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      front_sel_q <= 1'b0;
      scan_sel_q  <= 1'b0;
      vsync_q     <= 1'b0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      scan_sel_q  <= front_sel_q;
      vsync_q     <= vsync;
      dropped_q   <= dropped_d;
    end
  end

  always_comb begin
    back_addr  = '0;
    back_we    = 1'b0;
    back_wdata = '0;
    case (state_q)
      CLEAR: begin
        back_addr  = clr_addr;
        back_we    = clr_we & ~reset;
        back_wdata = clr_wdata;
      end
      DRAW: begin
        if (wr_fire) begin
          back_addr  = wr_addr;
          back_we    = wr_in_range;
          back_wdata = wr_color;
        end
      end
      default: ;
    endcase
  end

  assign bank0_addr  = front_sel_q ? back_addr : scan_addr;
  assign bank0_we    = front_sel_q & back_we;
  assign bank0_wdata = front_sel_q ? back_wdata : '0;
  assign bank1_addr  = front_sel_q ? scan_addr : back_addr;
  assign bank1_we    = ~front_sel_q & back_we;
  assign bank1_wdata = front_sel_q ? '0 : back_wdata;

  // Read data returns a cycle after the address, so steer with the delayed select.
  assign scan_data      = scan_sel_q ? bank1_rdata : bank0_rdata;
  assign front_sel      = front_sel_q;
  assign busy_clear     = reset | clr_busy;
  assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_fb_controller.sv
// Directed bench for fb_controller, built with a short frame (V_RES=8)
// so each clear sweep is 5120 cycles.
module tb_fb_controller;

  localparam int HR    = 640;
  localparam int VR    = 8;
  localparam int DEPTH = HR * VR;

  logic        clk, reset, vsync;
  logic [18:0] scan_addr;
  logic [2:0]  scan_data;
  logic        wr_valid, wr_ready;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [2:0]  wr_color;
  logic        frame_done;
  logic [18:0] bank0_addr, bank1_addr;
  logic        bank0_we, bank1_we;
  logic [2:0]  bank0_wdata, bank1_wdata, bank0_rdata, bank1_rdata;
  logic        front_sel, busy_clear;
  logic [7:0]  frames_dropped;

  int errors = 0;
  int checks = 0;

  fb_controller #(.H_RES(HR), .V_RES(VR), .PIX_W(3), .CLEAR_COLOR(3'b000), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .scan_addr(scan_addr), .scan_data(scan_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .frame_done(frame_done),
    .bank0_addr(bank0_addr), .bank0_we(bank0_we), .bank0_wdata(bank0_wdata), .bank0_rdata(bank0_rdata),
    .bank1_addr(bank1_addr), .bank1_we(bank1_we), .bank1_wdata(bank1_wdata), .bank1_rdata(bank1_rdata),
    .front_sel(front_sel), .busy_clear(busy_clear), .frames_dropped(frames_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; vsync = 1'b0; scan_addr = 19'd0; wr_valid = 1'b0;
    wr_x = 10'd0; wr_y = 9'd0; wr_color = 3'd0; frame_done = 1'b0;
    bank0_rdata = 3'b010; bank1_rdata = 3'b101;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    checks++; if (bank0_we !== 1'b0 || bank1_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b%b want 00", bank0_we, bank1_we); end
    checks++; if (busy_clear !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy_clear); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel: got %b want 0", front_sel); end
    checks++; if (frames_dropped !== 8'd0) begin errors++; $display("FAIL reset_dropped: got %0d want 0", frames_dropped); end
  endtask

  task automatic test_clear();
    int bad = 0;
    int bad_i = -1;
    logic [18:0] bad_a = '0;
    reset = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (bank1_we !== 1'b1 || bank1_addr !== 19'(i) || bank1_wdata !== 3'b000 ||
          bank0_we !== 1'b0 || busy_clear !== 1'b1 || wr_ready !== 1'b0) begin
        if (bad == 0) begin bad_i = i; bad_a = bank1_addr; end
        bad++;
      end
      @(negedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clear_sweep: %0d bad cycles, first at cycle %0d addr %0d, want none", bad, bad_i, bad_a); end
    checks++; if (busy_clear !== 1'b0) begin errors++; $display("FAIL clear_end_busy: got %b want 0", busy_clear); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clear_end_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_draw();
    wr_valid = 1'b1; wr_x = 10'd5; wr_y = 9'd2; wr_color = 3'b101;
    #1;
    checks++; if (bank1_addr !== 19'd1285 || bank1_we !== 1'b1 || bank1_wdata !== 3'b101) begin
      errors++; $display("FAIL draw_5_2: addr %0d we %b data %b want 1285 1 101", bank1_addr, bank1_we, bank1_wdata); end
    checks++; if (bank0_we !== 1'b0) begin errors++; $display("FAIL draw_front_we: got %b want 0", bank0_we); end
    @(negedge clk); #1;
    wr_x = 10'd639; wr_y = 9'd7; wr_color = 3'b011;
    #1;
    checks++; if (bank1_addr !== 19'd5119 || bank1_we !== 1'b1 || bank1_wdata !== 3'b011) begin
      errors++; $display("FAIL draw_last: addr %0d we %b data %b want 5119 1 011", bank1_addr, bank1_we, bank1_wdata); end
    @(negedge clk); #1;
    wr_x = 10'd640; wr_y = 9'd0;
    #1;
    checks++; if (wr_ready !== 1'b1 || bank1_we !== 1'b0) begin
      errors++; $display("FAIL draw_x_oob: ready %b we %b want 1 0", wr_ready, bank1_we); end
    @(negedge clk); #1;
    wr_x = 10'd0; wr_y = 9'd8;
    #1;
    checks++; if (wr_ready !== 1'b1 || bank1_we !== 1'b0) begin
      errors++; $display("FAIL draw_y_oob: ready %b we %b want 1 0", wr_ready, bank1_we); end
    @(negedge clk); #1;
    wr_valid = 1'b0;
    #1;
    checks++; if (bank1_we !== 1'b0 || bank1_addr !== 19'd0) begin
      errors++; $display("FAIL draw_idle: we %b addr %0d want 0 0", bank1_we, bank1_addr); end
  endtask

  task automatic test_drop_in_draw();
    vsync = 1'b1;
    @(negedge clk); #1;
    checks++; if (frames_dropped !== 8'd1 || front_sel !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL drop_draw: dropped %0d sel %b ready %b want 1 0 1", frames_dropped, front_sel, wr_ready); end
    vsync = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_swap();
    wr_valid = 1'b1; wr_x = 10'd1; wr_y = 9'd0; wr_color = 3'b111; frame_done = 1'b1;
    #1;
    checks++; if (bank1_we !== 1'b1 || bank1_addr !== 19'd1 || bank1_wdata !== 3'b111) begin
      errors++; $display("FAIL swap_done_write: we %b addr %0d data %b want 1 1 111", bank1_we, bank1_addr, bank1_wdata); end
    @(negedge clk); #1;
    frame_done = 1'b0; wr_x = 10'd3; wr_y = 9'd3;
    #1;
    checks++; if (wr_ready !== 1'b0 || bank1_we !== 1'b0) begin
      errors++; $display("FAIL swap_wait_stall: ready %b we %b want 0 0", wr_ready, bank1_we); end
    wr_valid = 1'b0;
    repeat (99) @(negedge clk);
    #1;
    scan_addr = 19'd12345; vsync = 1'b1;
    #1;
    checks++; if (front_sel !== 1'b0 || scan_data !== 3'b010 || bank0_addr !== 19'd12345) begin
      errors++; $display("FAIL swap_edge_cycle: sel %b data %b addr0 %0d want 0 010 12345", front_sel, scan_data, bank0_addr); end
    @(negedge clk); #1;
    checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL swap_front_sel: got %b want 1", front_sel); end
    checks++; if (bank0_we !== 1'b1 || bank0_addr !== 19'd0 || bank0_wdata !== 3'b000) begin
      errors++; $display("FAIL swap_clear_start: we %b addr %0d data %b want 1 0 000", bank0_we, bank0_addr, bank0_wdata); end
    checks++; if (bank1_we !== 1'b0 || bank1_addr !== 19'd12345 || scan_data !== 3'b010) begin
      errors++; $display("FAIL swap_front_side: we1 %b addr1 %0d data %b want 0 12345 010", bank1_we, bank1_addr, scan_data); end
    @(negedge clk); #1;
    checks++; if (scan_data !== 3'b101 || bank0_addr !== 19'd1 || frames_dropped !== 8'd1) begin
      errors++; $display("FAIL swap_scan_follow: data %b addr0 %0d dropped %0d want 101 1 1", scan_data, bank0_addr, frames_dropped); end
  endtask

  task automatic test_reset_midclear();
    vsync = 1'b0;
    repeat (999) @(negedge clk);
    #1;
    checks++; if (bank0_addr !== 19'd1000 || bank0_we !== 1'b1) begin
      errors++; $display("FAIL midclear_ptr: addr0 %0d we %b want 1000 1", bank0_addr, bank0_we); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (front_sel !== 1'b0 || bank0_we !== 1'b0 || bank1_we !== 1'b0 || busy_clear !== 1'b1 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL midclear_reset: sel %b we0 %b we1 %b busy %b ready %b want 0 0 0 1 0",
                         front_sel, bank0_we, bank1_we, busy_clear, wr_ready); end
    checks++; if (frames_dropped !== 8'd0) begin errors++; $display("FAIL midclear_dropped: got %0d want 0", frames_dropped); end
    reset = 1'b0;
    #1;
    checks++; if (bank1_we !== 1'b1 || bank1_addr !== 19'd0 || bank0_we !== 1'b0 || bank0_addr !== 19'd12345) begin
      errors++; $display("FAIL midclear_restart: we1 %b addr1 %0d we0 %b addr0 %0d want 1 0 0 12345",
                         bank1_we, bank1_addr, bank0_we, bank0_addr); end
    @(negedge clk); #1;
    checks++; if (bank1_addr !== 19'd1) begin errors++; $display("FAIL midclear_step: addr1 %0d want 1", bank1_addr); end
  endtask

  task automatic test_coincident();
    for (int i = 0; i < DEPTH + 10; i++) begin
      if (busy_clear !== 1'b1) break;
      @(negedge clk); #1;
    end
    checks++; if (busy_clear !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL coinc_clear_wait: busy %b ready %b want 0 1", busy_clear, wr_ready); end
    frame_done = 1'b1; vsync = 1'b1;
    @(negedge clk); #1;
    frame_done = 1'b0;
    checks++; if (frames_dropped !== 8'd1 || wr_ready !== 1'b0 || front_sel !== 1'b0) begin
      errors++; $display("FAIL coinc_edge: dropped %0d ready %b sel %b want 1 0 0", frames_dropped, wr_ready, front_sel); end
    vsync = 1'b0;
    @(negedge clk); #1;
    vsync = 1'b1;
    @(negedge clk); #1;
    checks++; if (front_sel !== 1'b1 || frames_dropped !== 8'd1 || busy_clear !== 1'b1) begin
      errors++; $display("FAIL coinc_swap: sel %b dropped %0d busy %b want 1 1 1", front_sel, frames_dropped, busy_clear); end
    vsync = 1'b0;
  endtask

  task automatic test_saturation();
    int sel_bad = 0;
    logic [7:0] exp_cnt;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk); #1;
      vsync = 1'b1;
      @(negedge clk); #1;
      vsync = 1'b0;
      if (front_sel !== 1'b1) sel_bad++;
      exp_cnt = (k + 1 > 255) ? 8'd255 : 8'(k + 1);
      if (k == 253 || k == 254 || k == 300) begin
        checks++; if (frames_dropped !== exp_cnt) begin
          errors++; $display("FAIL sat_count_%0d: got %0d want %0d", k, frames_dropped, exp_cnt); end
      end
    end
    checks++; if (sel_bad !== 0) begin errors++; $display("FAIL sat_front_sel: %0d cycles changed, want 0", sel_bad); end
    checks++; if (busy_clear !== 1'b1 || bank0_we !== 1'b1) begin
      errors++; $display("FAIL sat_still_clearing: busy %b we0 %b want 1 1", busy_clear, bank0_we); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_draw();
    test_drop_in_draw();
    test_swap();
    test_reset_midclear();
    test_coincident();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_controller.md
# fb_controller

Double-buffer controller for the 640x480, 3-bit-per-pixel frame store. Owns two external single-port synchronous-read pixel RAM banks: the front bank serves the VGA scanout reader, and the back bank is shared between a clear engine and the game renderer's write port. The front and back banks swap on vsync once the renderer has committed a frame. Sits between the game renderer, the VGA timing/scanout logic and the two RAM banks.

## Interface
Parameters:
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines
- PIX_W, 3, bits per pixel
- CLEAR_COLOR, 3'b000, value written by the clear engine
- CNT_W, 8, width of the dropped-frame counter

Ports:
- clk  in  1  single system/pixel clock
- reset  in  1  synchronous, active-high
- vsync  in  1  vertical sync in the clk domain; rising edge = frame boundary
- scan_addr  in  19  scanout read address, linear y*H_RES+x
- scan_data  out  PIX_W  front-bank pixel for the scan_addr of the previous cycle
- wr_valid  in  1  renderer write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_x  in  10  pixel column
- wr_y  in  9  pixel row
- wr_color  in  PIX_W  pixel value
- frame_done  in  1  single-cycle pulse: renderer finished the back frame
- bankN_addr  out  19  RAM address, N=0,1
- bankN_we  out  1  RAM write enable
- bankN_wdata  out  PIX_W  RAM write data
- bankN_rdata  in  PIX_W  RAM read data; 1-cycle latency
- front_sel  out  1  bank currently on screen
- busy_clear  out  1  clear engine active
- frames_dropped  out  CNT_W  count of vsync edges with no swap; saturating

## Operation
- Front bank: addr=scan_addr, we=0. scan_data = rdata of the front bank, selected by front_sel delayed 1 cycle so that a swap never mixes banks within one read.
- Back bank is driven by the state machine:
  - CLEAR: writes CLEAR_COLOR at clear_ptr, one address per cycle, from 0 to H_RES*V_RES-1 (307199). After the write of 307199 it goes to DRAW. wr_ready=0.
  - DRAW: wr_ready=1. An accepted write drives addr=wr_y*H_RES+wr_x (computed with shift-add: (y<<9)+(y<<7)+x), we=1, wdata=wr_color in the same cycle.
    - If wr_x>=H_RES or wr_y>=V_RES, the handshake still completes but we=0.
    - frame_done moves the FSM to WAIT_SWAP. A write accepted in the same cycle is performed.
  - WAIT_SWAP: wr_ready=0. On a vsync rising edge, front_sel toggles and the FSM goes to CLEAR with clear_ptr=0, i.e. the new back bank (the old front) is cleared.
- A vsync rising edge while in CLEAR or DRAW causes no swap and increments frames_dropped, saturating at 2^CNT_W-1.
- frame_done is ignored outside DRAW.
- frame_done and a vsync edge in the same DRAW cycle: go to WAIT_SWAP and count the edge as dropped.
- Back bank addr is 0 when idle; we=0 outside active writes.

## Timing
- Reset values: front_sel=0, FSM=CLEAR, clear_ptr=0, frames_dropped=0, vsync edge register=0.
- While reset is high: wr_ready=0, bank0_we=bank1_we=0, busy_clear=1.
- The first clear write (bank1, addr 0) occurs in the first cycle after reset deasserts.
- Clear lasts exactly 307200 cycles. busy_clear is high throughout, and wr_ready rises in the next cycle.
- Edge detect: vsync is registered once. An edge is seen in the cycle where vsync=1 and vsync_q=0. The swap is visible on front_sel at the following clk edge.
- Write latency: the RAM write happens in the handshake cycle; no buffering.
- Reset mid-operation aborts everything, including a clear in progress, and restarts from the reset state.

## Structure
- fb_pkg holds:
  - H_RES, V_RES and FB_DEPTH=307200
  - ADDR_W=19 and PIX_W
  - the FSM enum {CLEAR, DRAW, WAIT_SWAP}
  - an xy-to-linear address function
- One sub-module, fb_clear_engine: clear_ptr counter with start/busy/done, producing addr/we/wdata. The controller muxes its outputs onto the back bank.

## Test plan
- Release reset, run 307200 cycles: bank1 receives we=1 with data 0 at every address 0..307199 in order, bank0_we stays 0, and busy_clear falls and wr_ready rises at cycle 307200 after release.
- In DRAW, write x=5, y=2, color=3'b101: bank1_addr=1285, bank1_we=1, bank1_wdata=101 in the same cycle. Write x=639, y=479: address 307199.
- In DRAW, write x=640, y=0: handshake completes, bank1_we=0 for that cycle.
- frame_done, then a vsync edge 100 cycles later: front_sel goes 0->1 one cycle after the edge, bank0 clear starts at addr 0, and scan_data follows bank1_rdata from the second cycle after the edge.
- 300 vsync edges with no frame_done: front_sel stays constant and frames_dropped saturates at 255. frame_done coincident with a vsync edge increments the counter and enters WAIT_SWAP.
- Assert reset when clear_ptr=1000 after a swap: front_sel returns to 0 and clearing restarts on bank1 at addr 0.
